bus_slice_router: RTL and testbench

Registered, parametrised bit-slice router for netlist-flow regression designs. Takes one IN_W-bit input bus and drives NUM_OUT output lanes of OUT_W bits each. Each lane is a runtime-programmable, wrap-around part-select of the input. Data moves through a valid/ready pipeline with a 2-entry skid buffer, so pyverilog-style part-select and pointer assignments are exercised together with real sequential logic.

---
 rtl/bus_slice_router_pkg.sv | 38 +++
 rtl/slice_skid_buf.sv | 64 ++++++
 rtl/bus_slice_router.sv | 72 +++++++
 tb/tb_bus_slice_router.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_slice_router_pkg.sv
// Shared types and the wrap-around slice helper for bus_slice_router.
// slice_lane works on MAX_W-wide words; callers cast in/out.
package bus_slice_router_pkg;

  localparam int MAX_W = 64;

  typedef logic [MAX_W-1:0] word_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } buf_state_e;

  // bit j = data[(ofs + j) mod in_w], j < out_w.
  // ofs < in_w and j < in_w, so one subtract is a full modulo.
  function automatic word_t slice_lane(
    input word_t      data,
    input logic [6:0] in_w,
    input logic [6:0] out_w,
    input logic [6:0] ofs
  );
    word_t      r;
    logic [6:0] idx;
    logic [6:0] jv;
    r = '0;
    for (int j = 0; j < MAX_W; j++) begin
      jv = 7'(j);
      if (jv < out_w) begin
        idx = ofs + jv;
        if (idx >= in_w) idx = idx - in_w;
        r[jv[5:0]] = data[idx[5:0]];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/slice_skid_buf.sv
// Two-entry valid/ready FIFO buffer, registered outputs.
// in_ready/out_valid come only from state; out_data is the head entry.
module slice_skid_buf
  import bus_slice_router_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  buf_state_e    state;
  logic [DW-1:0] head;
  logic [DW-1:0] tail;
  logic          acc;
  logic          drn;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = head;
  assign acc       = in_valid && in_ready;
  assign drn       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            head  <= in_data;
            state <= ONE;
          end
        end
        ONE: begin
          if (acc && drn) begin
            head <= in_data;
          end else if (acc) begin
            tail  <= in_data;
            state <= FULL;
          end else if (drn) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (drn) begin
            head  <= tail;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/bus_slice_router.sv
// Registered bit-slice router: NUM_OUT programmable wrap-around lanes.
// Ports: cfg_* program lane offsets, in_*/out_* valid/ready data path.
module bus_slice_router
  import bus_slice_router_pkg::*;
#(
  parameter int IN_W    = 4,
  parameter int OUT_W   = 2,
  parameter int NUM_OUT = 2,
  parameter int OFS_W   = $clog2(IN_W),
  parameter int LANE_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [LANE_W-1:0]        cfg_lane,
  input  logic [OFS_W-1:0]         cfg_ofs,
  output logic                     cfg_err,
  input  logic                     cfg_err_clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_OUT*OUT_W-1:0] out_data
);

  localparam int DW = NUM_OUT * OUT_W;

  logic [OFS_W-1:0] ofs_q [NUM_OUT];
  logic             cfg_ok;
  logic [DW-1:0]    sliced;

  assign cfg_ok =
    ({1'b0, cfg_lane} < (LANE_W+1)'(NUM_OUT)) &&
    ({1'b0, cfg_ofs}  < (OFS_W+1)'(IN_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_OUT; k++)
        ofs_q[k] <= OFS_W'((k * OUT_W) % IN_W);
      cfg_err <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++)
        if (cfg_we && cfg_ok && cfg_lane == LANE_W'(k))
          ofs_q[k] <= cfg_ofs;
      // set beats clear
      if (cfg_we && !cfg_ok)
        cfg_err <= 1'b1;
      else if (cfg_err_clr)
        cfg_err <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
    assign sliced[k*OUT_W +: OUT_W] = OUT_W'(slice_lane(
      word_t'(in_data), 7'(IN_W), 7'(OUT_W), 7'(ofs_q[k])));
  end

  slice_skid_buf #(
    .DW(DW)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (sliced),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

endmodule

// File: tb/tb_bus_slice_router.sv
// Scoreboard bench for bus_slice_router (default params) plus a
// second instance (IN_W=5, NUM_OUT=3) where illegal config exists.
module tb_bus_slice_router;

  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [0:0] cfg_lane;
  logic [1:0] cfg_ofs;
  logic       cfg_err;
  logic       cfg_err_clr;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;

  logic       e_cfg_we;
  logic [1:0] e_cfg_lane;
  logic [2:0] e_cfg_ofs;
  logic       e_cfg_err;
  logic       e_cfg_err_clr;
  logic       e_in_valid;
  logic       e_in_ready;
  logic [4:0] e_in_data;
  logic       e_out_valid;
  logic       e_out_ready;
  logic [5:0] e_out_data;

  int         n_vec;
  int         n_bad;
  logic [3:0] exp_cur;
  logic [3:0] exp_q [$];

  bus_slice_router u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_lane   (cfg_lane),
    .cfg_ofs    (cfg_ofs),
    .cfg_err    (cfg_err),
    .cfg_err_clr(cfg_err_clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  bus_slice_router #(
    .IN_W   (5),
    .OUT_W  (2),
    .NUM_OUT(3)
  ) u_err (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (e_cfg_we),
    .cfg_lane   (e_cfg_lane),
    .cfg_ofs    (e_cfg_ofs),
    .cfg_err    (e_cfg_err),
    .cfg_err_clr(e_cfg_err_clr),
    .in_valid   (e_in_valid),
    .in_ready   (e_in_ready),
    .in_data    (e_in_data),
    .out_valid  (e_out_valid),
    .out_ready  (e_out_ready),
    .out_data   (e_out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at posedge+1, so negedge sees what the next edge uses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready)
        exp_q.push_back(exp_cur);
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_underflow got=%h want=none", out_data);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            n_bad++;
            $display("FAIL sb_data got=%h want=%h", out_data, e);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec         = 0;
    n_bad         = 0;
    rst_n         = 1'b0;
    cfg_we        = 1'b0;
    cfg_lane      = '0;
    cfg_ofs       = '0;
    cfg_err_clr   = 1'b0;
    in_valid      = 1'b0;
    in_data       = '0;
    out_ready     = 1'b1;
    exp_cur       = '0;
    e_cfg_we      = 1'b0;
    e_cfg_lane    = '0;
    e_cfg_ofs     = '0;
    e_cfg_err_clr = 1'b0;
    e_in_valid    = 1'b0;
    e_in_data     = '0;
    e_out_ready   = 1'b1;

    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_cfg_err",   32'(cfg_err),   32'd0);
    rst_n = 1'b1;
    tick();

    // defaults: 1011 passes straight through
    in_valid = 1'b1; in_data = 4'b1011; exp_cur = 4'b1011;
    tick();
    chk("lat1_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();

    // lane1 ofs=3 wraps: {in0,in3} | {in1,in0}
    cfg_we = 1'b1; cfg_lane = 1'b1; cfg_ofs = 2'd3;
    tick();
    cfg_we = 1'b0;
    in_valid = 1'b1; in_data = 4'b1001; exp_cur = 4'b1101;
    tick();
    in_valid = 1'b0;
    tick();

    // illegal config on the 5-bit instance
    e_cfg_we = 1'b1; e_cfg_lane = 2'd0; e_cfg_ofs = 3'd5;
    tick();
    e_cfg_we = 1'b0;
    chk("err_set", 32'(e_cfg_err), 32'd1);
    e_cfg_we = 1'b1; e_cfg_lane = 2'd3; e_cfg_ofs = 3'd0;
    e_cfg_err_clr = 1'b1;
    tick();
    e_cfg_we = 1'b0;
    chk("err_set_wins", 32'(e_cfg_err), 32'd1);
    tick();
    e_cfg_err_clr = 1'b0;
    chk("err_clr", 32'(e_cfg_err), 32'd0);
    // offsets still 0,2,4: 10110 -> {01,01,10}
    e_in_valid = 1'b1; e_in_data = 5'b10110;
    tick();
    e_in_valid = 1'b0;
    chk("err_ofs_kept_v", 32'(e_out_valid), 32'd1);
    chk("err_ofs_kept_d", 32'(e_out_data), 32'b010110);

    // backpressure (lane0 ofs0, lane1 ofs3)
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'b0011; exp_cur = 4'b1011;
    tick();
    in_data = 4'b1100; exp_cur = 4'b0100;
    tick();
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    in_data = 4'b1111; exp_cur = 4'b1111;
    tick();
    chk("bp_hold_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_data",  32'(out_data), 32'b1011);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    // cfg write and accept in the same cycle
    cfg_we = 1'b1; cfg_lane = 1'b0; cfg_ofs = 2'd1;
    in_valid = 1'b1; in_data = 4'b0110; exp_cur = 4'b0010;
    tick();
    cfg_we = 1'b0;
    exp_cur = 4'b0011;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();

    // reset with full buffer
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'b0101; exp_cur = 4'b0000;
    tick();
    in_data = 4'b1010; exp_cur = 4'b1111;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #2;
    exp_q.delete();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready),  32'd1);
    chk("mid_rst_data",  32'(out_data),  32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 4'b1011; exp_cur = 4'b1011;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
